rx_bit_sync: RTL and testbench

Bit-timing recovery stage directly upstream of `digital_rx`. Takes the oversampled 1-bit line level from the receive comparator and locks a phase counter to the bit boundaries with an early/late gate. Emits one majority-voted bit per bit period as the `i_bit_data`/`i_bit_valid` pair consumed by `digital_rx`. Runs for a programmed number of 32-bit words per frame, then returns to idle.

---
 rtl/rx_bit_sync_pkg.sv | 35 +++
 rtl/rx_bit_sync_frontend.sv | 83 ++++++++
 rtl/rx_bit_sync.sv | 178 +++++++++++++++++
 tb/tb_rx_bit_sync.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_bit_sync_pkg.sv
// Shared types and vote-window helpers for the rx_bit_sync bit-timing recovery block.
package rx_bit_sync_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    TRACK
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    HOLD,
    SKIP
  } corr_t;

  // The vote window is centred on OSR/2 and extends this many phases either side.
  localparam int unsigned VOTE_HALF_SPAN = 1;

  function automatic int unsigned vote_lo_ph(input int unsigned osr);
    return osr / 2 - VOTE_HALF_SPAN;
  endfunction

  function automatic int unsigned vote_mid_ph(input int unsigned osr);
    return osr / 2;
  endfunction

  function automatic int unsigned vote_hi_ph(input int unsigned osr);
    return osr / 2 + VOTE_HALF_SPAN;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_bit_sync_frontend.sv
// Line-sample front end: 2-flop synchroniser, optional 3-sample majority filter
// (RX_BIT_SYNC_GLITCH_FILTER_EN) and accepted-sample transition detector.
module rx_bit_sync_frontend
  import rx_bit_sync_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_sample_valid,
  input  logic i_sample,
  output logic o_valid,
  output logic o_level,
  output logic o_trans
);

  logic sync1_q, sync2_q;
  logic acc_valid, acc_level;
  logic prev_q, prev_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_sample;
      sync2_q <= sync1_q;
    end
  end

`ifdef RX_BIT_SYNC_GLITCH_FILTER_EN
  logic [1:0] hist_q, hist_d;
  logic       filt_q, filt_d;
  logic       fvalid_q, fvalid_d;

  // The strobe is delayed with the filtered level so edge detection and voting see the same latency.
  always_comb begin
    hist_d   = hist_q;
    filt_d   = filt_q;
    fvalid_d = i_sample_valid;
    if (i_sample_valid) begin
      hist_d = {hist_q[0], sync2_q};
      filt_d = maj3(sync2_q, hist_q[0], hist_q[1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q   <= '1;
      filt_q   <= 1'b1;
      fvalid_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      filt_q   <= filt_d;
      fvalid_q <= fvalid_d;
    end
  end

  always_comb begin
    acc_valid = fvalid_q;
    acc_level = filt_q;
  end
`else
  always_comb begin
    acc_valid = i_sample_valid;
    acc_level = sync2_q;
  end
`endif

  always_comb begin
    prev_d  = acc_valid ? acc_level : prev_q;
    o_valid = acc_valid;
    o_level = acc_level;
    o_trans = acc_valid && (acc_level != prev_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/rx_bit_sync.sv
// Early/late gated bit-timing recovery: locks a phase counter to line edges and emits one
// majority-voted bit per bit period. Optional glitch filter: RX_BIT_SYNC_GLITCH_FILTER_EN.
module rx_bit_sync
  import rx_bit_sync_pkg::*;
#(
  parameter int unsigned OSR    = 16,
  parameter int unsigned WNUM_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [WNUM_W-1:0] i_word_num,
  input  logic              i_sample_valid,
  input  logic              i_sample,
  output logic              o_bit_data,
  output logic              o_bit_valid,
  output logic              o_locked,
  output logic              o_done
);

  localparam int unsigned PH_W = $clog2(OSR);
  localparam int unsigned BC_W = WNUM_W + 5;

  localparam logic [PH_W-1:0] PH_LO   = PH_W'(vote_lo_ph(OSR));
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(vote_mid_ph(OSR));
  localparam logic [PH_W-1:0] PH_HI   = PH_W'(vote_hi_ph(OSR));
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(OSR / 2);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

  logic s_valid, s_level, s_trans;

  rx_bit_sync_frontend u_frontend (
    .clk            (clk),
    .rst            (rst),
    .i_sample_valid (i_sample_valid),
    .i_sample       (i_sample),
    .o_valid        (s_valid),
    .o_level        (s_level),
    .o_trans        (s_trans)
  );

  state_t          state_q, state_d;
  corr_t           corr_q, corr_d, corr_now;
  logic [PH_W-1:0] ph_q, ph_d;
  logic            hold_q, hold_d;
  logic            edge_seen_q, edge_seen_d;
  logic            v_lo_q, v_lo_d;
  logic            v_mid_q, v_mid_d;
  logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BC_W-1:0] target_q, target_d;
  logic            done_pend_q, done_pend_d;
  logic            bit_data_q, bit_data_d;
  logic            bit_valid_q, bit_valid_d;
  logic            done_q, done_d;
  logic            start_ok;

  always_comb begin
    state_d     = state_q;
    corr_d      = corr_q;
    corr_now    = corr_q;
    ph_d        = ph_q;
    hold_d      = hold_q;
    edge_seen_d = edge_seen_q;
    v_lo_d      = v_lo_q;
    v_mid_d     = v_mid_q;
    bit_cnt_d   = bit_cnt_q;
    target_d    = target_q;
    done_pend_d = done_pend_q;
    bit_data_d  = bit_data_q;
    bit_valid_d = 1'b0;
    done_d      = 1'b0;
    start_ok    = i_start && (i_word_num != '0);

    case (state_q)
      IDLE: begin
      end
      HUNT: begin
        if (s_valid && s_trans && !s_level) begin
          state_d = TRACK;
          ph_d    = PH_W'(1);
        end
      end
      TRACK: begin
        // Final bit strobe is out; o_done and the drop of o_locked land together next cycle.
        if (done_pend_q) begin
          done_pend_d = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end else if (s_valid) begin
          if (s_trans && (ph_q != '0) && !edge_seen_q) begin
            edge_seen_d = 1'b1;
            corr_now    = (ph_q < PH_HALF) ? HOLD : SKIP;
          end
          corr_d = corr_now;
          if (ph_q == PH_LO)  v_lo_d  = s_level;
          if (ph_q == PH_MID) v_mid_d = s_level;
          if (ph_q == PH_HI) begin
            bit_data_d  = maj3(v_lo_q, v_mid_q, s_level);
            bit_valid_d = 1'b1;
            bit_cnt_d   = bit_cnt_q + BC_W'(1);
            if (bit_cnt_d == target_q) done_pend_d = 1'b1;
          end
          // Corrections only take effect at the wrap, so the vote window is never cut or repeated.
          if (ph_q == PH_LAST) begin
            edge_seen_d = 1'b0;
            corr_d      = NONE;
            case (corr_now)
              HOLD: begin
                ph_d   = '0;
                hold_d = 1'b1;
              end
              SKIP:    ph_d = PH_W'(1);
              default: ph_d = '0;
            endcase
          end else if ((ph_q == '0) && hold_q) begin
            hold_d = 1'b0;
            ph_d   = '0;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_ok) begin
      target_d    = {i_word_num, 5'b0};
      bit_cnt_d   = '0;
      corr_d      = NONE;
      edge_seen_d = 1'b0;
      hold_d      = 1'b0;
      ph_d        = '0;
      done_pend_d = 1'b0;
      done_d      = 1'b0;
      state_d     = HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      corr_q      <= NONE;
      ph_q        <= '0;
      hold_q      <= 1'b0;
      edge_seen_q <= 1'b0;
      v_lo_q      <= 1'b0;
      v_mid_q     <= 1'b0;
      bit_cnt_q   <= '0;
      target_q    <= '0;
      done_pend_q <= 1'b0;
      bit_data_q  <= 1'b0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      corr_q      <= corr_d;
      ph_q        <= ph_d;
      hold_q      <= hold_d;
      edge_seen_q <= edge_seen_d;
      v_lo_q      <= v_lo_d;
      v_mid_q     <= v_mid_d;
      bit_cnt_q   <= bit_cnt_d;
      target_q    <= target_d;
      done_pend_q <= done_pend_d;
      bit_data_q  <= bit_data_d;
      bit_valid_q <= bit_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    o_bit_data  = bit_data_q;
    o_bit_valid = bit_valid_q;
    o_done      = done_q;
    o_locked    = (state_q == TRACK);
  end

endmodule

// File: tb/tb_rx_bit_sync.sv
// Self-checking bench for rx_bit_sync: recovered bits must equal the transmitted NRZ bits,
// with frame length, done timing and strobe spacing checked against the bit-timing rules.
`timescale 1ns/1ps
module tb_rx_bit_sync;

  localparam int unsigned OSR    = 16;
  localparam int unsigned WNUM_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [WNUM_W-1:0] i_word_num;
  logic              i_sample_valid;
  logic              i_sample;
  logic              o_bit_data, o_bit_valid, o_locked, o_done;

  rx_bit_sync #(.OSR(OSR), .WNUM_W(WNUM_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_word_num     (i_word_num),
    .i_sample_valid (i_sample_valid),
    .i_sample       (i_sample),
    .o_bit_data     (o_bit_data),
    .o_bit_valid    (o_bit_valid),
    .o_locked       (o_locked),
    .o_done         (o_done)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Source description in accepted-sample units: one level and one length per bit.
  bit src_q[$];
  int per_q[$];
  bit exp_q[$];
  int glitch_bit = -1;
  int glitch_idx = -1;
  bit vh1 = 1'b1, vh2 = 1'b1;

  bit got_q[$];
  int vcyc_q[$];
  int done_q[$];
  bit locked_seen = 1'b0;

  always @(negedge clk) begin
    if (o_bit_valid) begin
      got_q.push_back(o_bit_data);
      vcyc_q.push_back(cyc);
      check_eq("valid_in_track", o_locked, 1);
    end
    if (o_done) done_q.push_back(cyc);
    if (o_locked) locked_seen = 1'b1;
  end

  // The strobe is issued two cycles after the level so it pairs with the synchronised sample.
  task automatic put_sample(input bit lvl, input bit gaps);
    bit v;
    do begin
      v = gaps ? ($urandom_range(3) != 0) : 1'b1;
      @(negedge clk);
      i_sample       = lvl;
      i_sample_valid = vh2;
      vh2            = vh1;
      vh1            = v;
    end while (!v);
  endtask

  task automatic send(input bit gaps);
    for (int i = 0; i < 20; i++) put_sample(1'b1, gaps);
    for (int b = 0; b < src_q.size(); b++)
      for (int s = 0; s < per_q[b]; s++)
        put_sample(((b == glitch_bit) && (s == glitch_idx)) ? 1'b0 : src_q[b], gaps);
    for (int i = 0; i < 40; i++) put_sample(1'b1, gaps);
  endtask

  task automatic new_frame();
    src_q.delete(); per_q.delete(); exp_q.delete();
    got_q.delete(); vcyc_q.delete(); done_q.delete();
    locked_seen = 1'b0;
    glitch_bit  = -1;
    glitch_idx  = -1;
  endtask

  task automatic push_word(input logic [31:0] w, input int per);
    for (int k = 0; k < 32; k++) begin
      src_q.push_back(w[k]);
      per_q.push_back(per);
    end
  endtask

  // Frames open with a 0 so HUNT has a falling edge out of the idle-high line.
  task automatic push_rand(input int n, input int per);
    for (int k = 0; k < n; k++) begin
      src_q.push_back((k == 0) ? 1'b0 : 1'($urandom_range(1)));
      per_q.push_back(per);
    end
  endtask

  task automatic push_alt(input int n, input int per);
    for (int k = 0; k < n; k++) begin
      src_q.push_back(1'(k % 2));
      per_q.push_back(per);
    end
  endtask

  task automatic arm(input int words);
    @(negedge clk);
    i_start    = 1'b1;
    i_word_num = WNUM_W'(words);
    @(negedge clk);
    i_start    = 1'b0;
  endtask

  // mode 1: every strobe OSR apart; mode 2: within one clk of OSR; other: no spacing check.
  task automatic check_frame(input string name, input int nbits, input int mode);
    int off;
    check_eq({name, ":count"}, got_q.size(), nbits);
    for (int i = 0; i < nbits && i < got_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s:bit%0d", name, i), got_q[i], exp_q[i]);
    check_eq({name, ":done_n"}, done_q.size(), 1);
    if (done_q.size() > 0 && vcyc_q.size() > 0)
      check_eq({name, ":done_time"}, done_q[0], vcyc_q[vcyc_q.size()-1] + 1);
    check_eq({name, ":unlocked_after"}, o_locked, 0);
    off = 0;
    for (int i = 1; i < vcyc_q.size(); i++) begin
      if (mode == 1 && (vcyc_q[i] - vcyc_q[i-1]) != OSR) off++;
      if (mode == 2 && ((vcyc_q[i] - vcyc_q[i-1]) < OSR - 1 || (vcyc_q[i] - vcyc_q[i-1]) > OSR + 1)) off++;
    end
    if (mode == 1 || mode == 2) check_eq({name, ":spacing_off"}, off, 0);
  endtask

  initial begin
    int n15, n_other, exp15, wait_n;
    rst            = 1'b1;
    i_start        = 1'b0;
    i_word_num     = '0;
    i_sample_valid = 1'b1;
    i_sample       = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset:data",   o_bit_data,  0);
    check_eq("reset:valid",  o_bit_valid, 0);
    check_eq("reset:locked", o_locked,    0);
    check_eq("reset:done",   o_done,      0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    new_frame();
    push_word(32'h04030200, OSR);
    push_word(32'h08070605, OSR);
    exp_q = src_q;
    arm(2); send(1'b0);
    check_frame("ideal", 64, 1);

    new_frame();
    push_alt(32, OSR + 1);
    exp_q = src_q;
    arm(1); send(1'b0);
    check_frame("drift_late", 32, 2);

    new_frame();
    push_alt(32, OSR - 1);
    exp_q = src_q;
    arm(1); send(1'b0);
    check_frame("drift_early", 32, 2);

    new_frame();
    push_word(32'hFFFF_FFFE, OSR);
    glitch_bit = 5;
    glitch_idx = OSR / 2;
    exp_q = src_q;
    arm(1); send(1'b0);
    check_frame("glitch", 32, 0);
    n15 = 0; n_other = 0;
    for (int i = 1; i < vcyc_q.size(); i++) begin
      if ((vcyc_q[i] - vcyc_q[i-1]) == OSR - 1) n15++;
      else if ((vcyc_q[i] - vcyc_q[i-1]) != OSR) n_other++;
    end
`ifdef RX_BIT_SYNC_GLITCH_FILTER_EN
    exp15 = 0;
`else
    exp15 = 1;
`endif
    check_eq("glitch:short_bits", n15, exp15);
    check_eq("glitch:odd_spacing", n_other, 0);

    new_frame();
    push_rand(32, OSR);
    arm(0); send(1'b0);
    check_eq("zero_words:bits", got_q.size(), 0);
    check_eq("zero_words:done", done_q.size(), 0);
    check_eq("zero_words:locked", locked_seen, 0);

    new_frame();
    push_rand(64, OSR);
    exp_q = src_q;
    arm(2); send(1'b1);
    check_frame("gaps", 64, 0);

    new_frame();
    begin
      bit a[11] = '{0, 1, 0, 1, 1, 0, 0, 1, 1, 1, 1};
      for (int k = 0; k < 11; k++) begin src_q.push_back(a[k]); per_q.push_back(OSR); end
      for (int k = 0; k < 10; k++) exp_q.push_back(a[k]);
      for (int k = 0; k < 5; k++) begin src_q.push_back(1'b1); per_q.push_back(OSR); end
      for (int k = 0; k < 32; k++) begin
        src_q.push_back((k == 0) ? 1'b0 : 1'($urandom_range(1)));
        per_q.push_back(OSR);
        exp_q.push_back(src_q[src_q.size()-1]);
      end
    end
    arm(1);
    fork
      send(1'b0);
      begin
        wait_n = 0;
        while (got_q.size() < 10 && wait_n < 5000) begin @(negedge clk); wait_n++; end
        check_eq("restart:reach10", got_q.size() >= 10, 1);
        @(negedge clk);
        i_start    = 1'b1;
        i_word_num = WNUM_W'(1);
        @(negedge clk);
        i_start    = 1'b0;
      end
    join
    check_frame("restart", 42, 0);

    new_frame();
    push_rand(32, OSR);
    arm(1);
    fork
      send(1'b0);
      begin
        wait_n = 0;
        while (got_q.size() < 20 && wait_n < 5000) begin @(negedge clk); wait_n++; end
        check_eq("rst_mid:reach20", got_q.size() >= 20, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid:data",   o_bit_data,  0);
        check_eq("rst_mid:valid",  o_bit_valid, 0);
        check_eq("rst_mid:locked", o_locked,    0);
        check_eq("rst_mid:done",   o_done,      0);
        rst = 1'b0;
      end
    join
    check_eq("rst_mid:bits", got_q.size(), 20);
    check_eq("rst_mid:no_done", done_q.size(), 0);

    new_frame();
    push_rand(32, OSR);
    exp_q = src_q;
    arm(1); send(1'b0);
    check_frame("post_rst", 32, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
